expander_spi_scheduler: RTL

Owns the SPI link to the MCP23S17 GPIO expander on the LS connector and schedules all traffic on it. After reset it runs a fixed configuration sequence. It then arbitrates between three sources: host output writes, the expander interrupt (JS_INTA) and a periodic poll timer. Port A is configured as inputs (buttons/joystick) and port B as outputs, and the block presents the current port A value to the core.

---
 rtl/mcp23s17_pkg.sv | 44 ++++
 rtl/spi_frame_engine.sv | 102 ++++++++++
 rtl/expander_spi_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mcp23s17_pkg.sv
// rtl/mcp23s17_pkg.sv - MCP23S17 register map, configuration table and scheduler state type
package mcp23s17_pkg;

  localparam logic [7:0] REG_IODIRA   = 8'h00;
  localparam logic [7:0] REG_IODIRB   = 8'h01;
  localparam logic [7:0] REG_GPINTENA = 8'h04;
  localparam logic [7:0] REG_IOCON    = 8'h0A;
  localparam logic [7:0] REG_GPPUA    = 8'h0C;
  localparam logic [7:0] REG_GPIOA    = 8'h12;
  localparam logic [7:0] REG_OLATB    = 8'h15;

  localparam logic [3:0] OPCODE_BASE = 4'b0100;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rd;
  } init_entry_t;

  localparam int INIT_LEN = 7;

  // IOCON=0x28: sequential addressing off, hardware addressing on
  localparam init_entry_t INIT_TABLE [INIT_LEN] = '{
    '{REG_IOCON,    8'h28, 1'b0},
    '{REG_IODIRA,   8'hFF, 1'b0},
    '{REG_IODIRB,   8'h00, 1'b0},
    '{REG_GPPUA,    8'hFF, 1'b0},
    '{REG_GPINTENA, 8'hFF, 1'b0},
    '{REG_OLATB,    8'h00, 1'b0},
    '{REG_GPIOA,    8'h00, 1'b1}
  };

  typedef enum logic [1:0] {
    ST_INIT_LOAD,
    ST_XFER,
    ST_GAP,
    ST_IDLE
  } sched_state_t;

  function automatic logic [7:0] spi_opcode(input logic [2:0] hw_addr, input logic rd);
    return {OPCODE_BASE, hw_addr, rd};
  endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// rtl/spi_frame_engine.sv - 24-bit mode-0 SPI frame shifter with prescaler and start/done handshake
module spi_frame_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic        start,
  input  logic [23:0] tx_data,
  output logic        done,
  output logic [7:0]  rx_data,
  input  logic        spi_miso,
  output logic        spi_mosi,
  output logic        spi_sck,
  output logic        spi_cs_n
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active_q, active_d;
  logic             cs_q, cs_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             done_q, done_d;
  logic [23:0]      shift_q, shift_d;
  logic [7:0]       rx_q, rx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;

  always_comb begin
    active_d = active_q;
    cs_d     = cs_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;
    shift_d  = shift_q;
    rx_d     = rx_q;
    div_d    = div_q;
    bit_d    = bit_q;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        cs_d     = 1'b0;
        sck_d    = 1'b0;
        shift_d  = tx_data;
        mosi_d   = tx_data[23];
        div_d    = '0;
        bit_d    = '0;
      end
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
      if (sck_q) begin
        sck_d   = 1'b0;
        bit_d   = bit_q + 5'd1;
        shift_d = {shift_q[22:0], 1'b0};
        mosi_d  = shift_q[22];
      end else if (bit_q == 5'd24) begin
        // trailing low phase finished: release CS and report the frame
        cs_d     = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b1;
        mosi_d   = 1'b0;
      end else begin
        sck_d = 1'b1;
        rx_d  = {rx_q[6:0], spi_miso};
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      active_q <= 1'b0;
      cs_q     <= 1'b1;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
      shift_q  <= '0;
      rx_q     <= '0;
      div_q    <= '0;
      bit_q    <= '0;
    end else begin
      active_q <= active_d;
      cs_q     <= cs_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
      shift_q  <= shift_d;
      rx_q     <= rx_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
    end
  end

  assign done     = done_q;
  assign rx_data  = rx_q;
  assign spi_mosi = mosi_q;
  assign spi_sck  = sck_q;
  assign spi_cs_n = cs_q;

endmodule

// File: rtl/expander_spi_scheduler.sv
// rtl/expander_spi_scheduler.sv - MCP23S17 link scheduler: init sequence, arbitration and poll timer
module expander_spi_scheduler
  import mcp23s17_pkg::*;
#(
  parameter int         CLK_DIV     = 4,
  parameter int         POLL_PERIOD = 2800000,
  parameter logic [2:0] HW_ADDR     = 3'b000
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic       locked,
  input  logic       JS_INTA,
  input  logic       JS_MISO,
  output logic       JS_MOSI,
  output logic       JS_SCK,
  output logic       JS_CS,
  input  logic       wr_req,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic [7:0] porta_value,
  output logic       porta_valid,
  output logic       init_done,
  output logic       busy
);

  localparam int TIMER_W = $clog2(POLL_PERIOD);
  localparam int GAP_W   = $clog2(2 * CLK_DIV);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(POLL_PERIOD - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(2 * CLK_DIV - 1);

  logic srst_n;
  assign srst_n = RESET_N & locked;

  sched_state_t     state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic             init_done_q, init_done_d;
  logic [7:0]       porta_q, porta_d;
  logic             cur_rd_q, cur_rd_d;
  logic             cur_host_q, cur_host_d;
  logic [1:0]       inta_sync_q, inta_sync_d;

  init_entry_t init_ent;
  logic        eng_start;
  logic [23:0] eng_tx;
  logic        eng_done;
  logic [7:0]  eng_rx;
  logic        rd_done;

  spi_frame_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_engine (
    .clk     (clk),
    .srst_n  (srst_n),
    .start   (eng_start),
    .tx_data (eng_tx),
    .done    (eng_done),
    .rx_data (eng_rx),
    .spi_miso(JS_MISO),
    .spi_mosi(JS_MOSI),
    .spi_sck (JS_SCK),
    .spi_cs_n(JS_CS)
  );

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    gap_d       = gap_q;
    timer_d     = timer_q;
    init_done_d = init_done_q;
    cur_rd_d    = cur_rd_q;
    cur_host_d  = cur_host_q;
    inta_sync_d = {inta_sync_q[0], JS_INTA};
    eng_start   = 1'b0;
    eng_tx      = '0;
    init_ent    = INIT_TABLE[step_q];
    rd_done     = eng_done & cur_rd_q;
    porta_d     = rd_done ? eng_rx : porta_q;

    // any completed GPIOA read also clears the expander interrupt, so the poll restarts
    if (rd_done) begin
      timer_d = '0;
    end else if ((state_q == ST_IDLE || state_q == ST_XFER) && timer_q != TIMER_MAX) begin
      timer_d = timer_q + TIMER_W'(1);
    end

    case (state_q)
      ST_INIT_LOAD: begin
        eng_start  = 1'b1;
        eng_tx     = {spi_opcode(HW_ADDR, init_ent.rd), init_ent.addr, init_ent.data};
        cur_rd_d   = init_ent.rd;
        cur_host_d = 1'b0;
        state_d    = ST_XFER;
      end
      ST_XFER: begin
        if (eng_done) begin
          gap_d   = '0;
          state_d = ST_GAP;
          if (!init_done_q) begin
            if (step_q == 3'(INIT_LEN - 1)) begin
              init_done_d = 1'b1;
            end else begin
              step_d = step_q + 3'd1;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = init_done_q ? ST_IDLE : ST_INIT_LOAD;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_IDLE: begin
        if (wr_req) begin
          eng_start  = 1'b1;
          eng_tx     = {spi_opcode(HW_ADDR, 1'b0), REG_OLATB, wr_data};
          cur_rd_d   = 1'b0;
          cur_host_d = 1'b1;
          state_d    = ST_XFER;
        end else if (!inta_sync_q[1] || timer_q == TIMER_MAX) begin
          eng_start  = 1'b1;
          eng_tx     = {spi_opcode(HW_ADDR, 1'b1), REG_GPIOA, 8'h00};
          cur_rd_d   = 1'b1;
          cur_host_d = 1'b0;
          state_d    = ST_XFER;
        end
      end
      default: state_d = ST_INIT_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q     <= ST_INIT_LOAD;
      step_q      <= '0;
      gap_q       <= '0;
      timer_q     <= '0;
      init_done_q <= 1'b0;
      porta_q     <= 8'h00;
      cur_rd_q    <= 1'b0;
      cur_host_q  <= 1'b0;
      inta_sync_q <= 2'b11;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      gap_q       <= gap_d;
      timer_q     <= timer_d;
      init_done_q <= init_done_d;
      porta_q     <= porta_d;
      cur_rd_q    <= cur_rd_d;
      cur_host_q  <= cur_host_d;
      inta_sync_q <= inta_sync_d;
    end
  end

  // completion strobes coincide with the cycle JS_CS returns high
  assign wr_ack      = eng_done & cur_host_q;
  assign porta_valid = rd_done;
  assign porta_value = porta_d;
  assign init_done   = init_done_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
